// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues req/ack word fetches and feeds IF/ID.
// One-cycle fetch-to-output latency; a one-entry skid absorbs a word acked under stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        slot_free;
  logic [31:0] next_addr;
  logic [31:0] rd_pc;

  assign slot_free = !if_valid_q || !stall;
  assign next_addr = req_addr_q + 32'd4;
  assign rd_pc     = redirect_pc & ~32'd3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    // An unstalled slot is consumed this edge; a refill below overrides this.
    if_valid_d    = if_valid_q && stall;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    skid_vld_d    = skid_vld_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;

    if (redirect_valid) begin
      if_valid_d = 1'b0;
      skid_vld_d = 1'b0;
      pc_d       = rd_pc;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            req_addr_d = rd_pc;
            state_d    = FETCH;
          end else begin
            state_d    = DRAIN;
          end
        end
        DRAIN:   state_d = DRAIN;
        default: begin
          req_addr_d = rd_pc;
          state_d    = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            pc_d = next_addr;
            if (slot_free) begin
              if_valid_d    = 1'b1;
              if_instr_d    = imem_rdata;
              if_pc_d       = req_addr_q;
              if_pc_plus4_d = next_addr;
              req_addr_d    = next_addr;
            end else begin
              skid_vld_d   = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc_d    = req_addr_q;
              state_d      = WAIT_SLOT;
            end
          end
        end
        WAIT_SLOT: begin
          if (slot_free) begin
            if_valid_d    = skid_vld_q;
            if_instr_d    = skid_instr_q;
            if_pc_d       = skid_pc_q;
            if_pc_plus4_d = skid_pc_q + 32'd4;
            skid_vld_d    = 1'b0;
            req_addr_d    = pc_q;
            state_d       = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      skid_vld_q    <= 1'b0;
      skid_instr_q  <= 32'd0;
      skid_pc_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      skid_vld_q    <= skid_vld_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = req_addr_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected (pc) stream queued by stimulus, checked on every consumed output.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_cfg = 1;
  int wcnt = 0;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks the lat_cfg-th cycle of each request; drops state when req falls.
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      wcnt = 0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) wcnt = 0;
      imem_ack = (wcnt >= lat_cfg - 1);
      wcnt++;
    end
    imem_rdata = mem_word(imem_addr);
  end

  // Monitor: an output is consumed whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got pc %h expected none", if_pc);
      end else begin
        logic [31:0] ep;
        ep = exp_q.pop_front();
        chk("if_pc", if_pc, ep);
        chk("if_instr", if_instr, mem_word(ep));
        chk("if_pc_plus4", if_pc_plus4, ep + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    lat_cfg = lat;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);

    // Streaming with zero-wait memory
    do_reset(1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    chk("s1_req", {31'd0, imem_req}, 32'd1);
    chk("s1_addr0", imem_addr, 32'h0);
    tick(); chk("s1_addr4", imem_addr, 32'h4);
    tick(); chk("s1_addr8", imem_addr, 32'h8);
    tick(); chk("s1_addrC", imem_addr, 32'hC);

    // Stall while word 8 is acked: goes to skid, request drops
    do_reset(1);
    foreach (exp_q[i]) chk("s1_leftover", exp_q[i], 32'hFFFF_FFFF);
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    repeat (3) tick();
    stall = 1'b1;
    chk("s2_addr8", imem_addr, 32'h8);
    tick();
    chk("s2_req_skid", {31'd0, imem_req}, 32'd0);
    chk("s2_hold_pc", if_pc, 32'h4);
    repeat (2) tick();
    chk("s2_hold_pc3", if_pc, 32'h4);
    chk("s2_hold_valid", {31'd0, if_valid}, 32'd1);
    chk("s2_req_still0", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("s2_addr_resume", imem_addr, 32'hC);
    repeat (2) tick();

    // Redirect with 2-cycle memory while 0x10 is outstanding
    do_reset(2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    repeat (9) tick();
    chk("s3_addr10", imem_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("s3_drain_addr", imem_addr, 32'h10);
    chk("s3_drain_req", {31'd0, imem_req}, 32'd1);
    chk("s3_drain_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("s3_new_addr", imem_addr, 32'h100);
    chk("s3_gap_valid", {31'd0, if_valid}, 32'd0);
    repeat (4) tick();

    // Redirect coincident with ack and stall
    do_reset(1);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    repeat (2) tick();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    chk("s4_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("s4_addr", imem_addr, 32'h200);
    repeat (2) tick();

    // Unaligned redirect near top of memory, address wrap
    do_reset(1);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("s5_addr_wrap", imem_addr, 32'h0);
    chk("s5_pc4_wrap", if_pc_plus4, 32'h0);
    tick();

    // Reset asserted mid-DRAIN
    do_reset(2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'h0);
    repeat (7) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("s6_drain_addr", imem_addr, 32'hC);
    chk("s6_drain_pc", if_pc, 32'h8);
    rst = 1'b1;
    tick();
    chk("s6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("s6_rst_addr", imem_addr, 32'h0);
    chk("s6_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("s6_rst_instr", if_instr, 32'd0);
    chk("s6_rst_pc", if_pc, 32'd0);
    chk("s6_rst_pc4", if_pc_plus4, 32'd0);
    rst = 1'b0;
    tick();
    chk("s6_restart_addr", imem_addr, 32'h0);
    chk("s6_restart_req", {31'd0, imem_req}, 32'd1);
    repeat (4) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RV32I pipeline. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It presents fetched instructions to the downstream IF/ID pipeline register and honours a downstream stall and a redirect from EX (taken branch or jump). A one-entry skid buffer keeps the memory handshake legal when a stall arrives while a request is in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  request valid; combinational from state.
- imem_addr  out  32  word address of the current/outstanding request; bits [1:0] always 0.
- imem_ack  in  1  memory completes the request in this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ack=1.
- stall  in  1  downstream holds IF/ID; the current if_* output must not change.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0.
- if_valid  out  1  if_instr/if_pc/if_pc_plus4 hold a valid instruction (registered).
- if_instr  out  32  fetched instruction (registered).
- if_pc  out  32  PC of if_instr (registered).
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32 (registered).

## Operation
- Registers: pc (next fetch address), req_addr (drives imem_addr), output slot (if_*), skid {valid, instr, pc}, state.
- States: IDLE, FETCH, WAIT_SLOT, DRAIN. imem_req=1 in FETCH and DRAIN only.
- slot_free = !if_valid || !stall.
- IDLE: go to FETCH with req_addr=pc.
- FETCH, ack=0: hold req and req_addr. A request, once raised, stays high with a stable address until acked.
- FETCH, ack=1, slot_free=1: load the slot with {imem_rdata, req_addr, req_addr+4}, set if_valid=1, set pc and req_addr to req_addr+4, stay in FETCH. Back-to-back requests give one instruction per cycle.
- FETCH, ack=1, slot_free=0: capture the word into skid, set pc=req_addr+4, go to WAIT_SLOT.
- WAIT_SLOT: when slot_free=1, move skid to the slot, clear skid, set req_addr=pc, go to FETCH.
- When the slot is consumed (stall=0) and nothing refills it, if_valid drops to 0.
- Redirect (redirect_valid=1) has priority over all other events, including stall:
  - if_valid<=0 and skid cleared at the same edge.
  - pc<={redirect_pc[31:2],2'b00}.
  - In FETCH with ack=1, or in WAIT_SLOT/IDLE: discard any returned data, set req_addr=new pc, state=FETCH.
  - In FETCH with ack=0: go to DRAIN; req_addr keeps the old address.
  - In DRAIN: update pc only and stay in DRAIN.
- DRAIN: hold req at the old address. On ack, discard the data, set req_addr=pc, go to FETCH. Stalled outputs are unaffected because if_valid is already 0.
- Arithmetic: all PC additions are 32-bit and wrap, so 32'hFFFF_FFFC+4=0.

## Timing
- Reset values (after a rst edge): state=IDLE, imem_req=0, pc=req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, skid cleared.
- Reset during DRAIN or with a request outstanding abandons the request. The memory tolerates imem_req dropping at reset.
- First imem_req=1 appears in the second cycle after rst deasserts (IDLE, then FETCH).
- Latency: a word acked at edge N shows on if_* after edge N; if_valid=1 from edge N to N+1.
- Redirect at edge N with no outstanding request: new address on imem_addr in cycle N→N+1. With a zero-wait ack, the first redirected instruction is valid after edge N+1.
- Redirect with a request outstanding: add the remaining wait of the old request.
- Output changes only at edges where stall=0, or where redirect_valid=1 (flush).

## Test plan
- Reset release, memory always acks, no stall -> imem_addr 0,4,8,C on consecutive cycles; if_pc 0,4,8 with if_valid=1 every cycle from the third post-reset edge; if_pc_plus4=if_pc+4.
- Stall held 3 cycles while req at addr 8 is acked -> if_pc stays 4; word 8 goes to skid and imem_req=0. On stall release, if_pc=8 then 0xC with no lost or duplicate instruction.
- Memory with 2-cycle ack; redirect_pc=0x100 while addr 0x10 is outstanding -> DRAIN holds imem_addr=0x10 until ack; word 0x10 is never output; next imem_addr=0x100; if_valid=0 in between.
- Redirect coincident with ack and stall=1 -> if_valid=0 at the next edge; acked data dropped; imem_addr=redirect target.
- redirect_pc=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then imem_addr wraps to 0x0000_0000; if_pc_plus4 of the first word is 0.
- Assert rst mid-DRAIN -> all outputs take their reset values at the next edge; fetch restarts at RESET_PC.
